// File: rtl/forth_stack_pkg.sv
// Shared definitions for the Forth core stacks: data width and the
// strobe-combination op codes used by the core, the stack and its bench.
package forth_stack_pkg;

   localparam int DW = 16;

   typedef enum logic [2:0] {
      OP_HOLD      = 3'd0,
      OP_PUSH      = 3'd1,
      OP_POP       = 3'd2,
      OP_POP_PUSH  = 3'd3,
      OP_POP2      = 3'd4,
      OP_POP2_PUSH = 3'd5
   } stack_op_e;

   // pop2 dominates pop when both strobes are high.
   function automatic stack_op_e decode_op(input logic pop, input logic pop2, input logic push);
      stack_op_e op;
      if (pop2) begin
         op = push ? OP_POP2_PUSH : OP_POP2;
      end else if (pop) begin
         op = push ? OP_POP_PUSH : OP_POP;
      end else begin
         op = push ? OP_PUSH : OP_HOLD;
      end
      return op;
   endfunction

endpackage

// File: rtl/forth_stack_ram.sv
// Spill array below the cached TOS/NOS: DEPTH-2 words, one write port,
// two asynchronous read ports; out-of-range reads return 0.
module forth_stack_ram
   import forth_stack_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [DW-1:0] rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [DW-1:0] rdata_b
);

   localparam int N = DEPTH - 2;

   logic [DW-1:0] mem_q [N];

   // Storage update: cleared on reset, single write otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (we && (waddr == AW'(i))) begin
               mem_q[i] <= wdata;
            end else begin
               mem_q[i] <= mem_q[i];
            end
         end
      end
   end

   // Read muxes; an address matching no entry yields 0.
   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      for (int i = 0; i < N; i++) begin
         rdata_a = (raddr_a == AW'(i)) ? mem_q[i] : rdata_a;
         rdata_b = (raddr_b == AW'(i)) ? mem_q[i] : rdata_b;
      end
   end

endmodule

// File: rtl/forth_stack.sv
// Hardware LIFO for the Forth core: TOS/NOS cached in registers, deeper
// entries spilled to forth_stack_ram, sticky overflow/underflow flags.
module forth_stack
   import forth_stack_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CW    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pop,
   input  logic          pop2,
   output logic [DW-1:0] first,
   output logic [DW-1:0] second,
   input  logic          push,
   input  logic [DW-1:0] value,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          overflow,
   output logic          underflow
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] TWO_C   = CW'(2);

   logic [DW-1:0] tos_q, tos_d, nos_q, nos_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d, empty_q, empty_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   logic [CW-1:0] sp_s;
   logic [DW-1:0] rd_a_s, rd_b_s, fill1_s, fill2_s;
   logic          we_s, under_s;
   stack_op_e     op_s;

   assign sp_s    = (count_q >= TWO_C) ? (count_q - TWO_C) : '0;
   assign fill1_s = (sp_s >= ONE_C) ? rd_a_s : '0;
   assign fill2_s = (sp_s >= TWO_C) ? rd_b_s : '0;
   assign op_s    = decode_op(pop, pop2, push);
   assign under_s = pop2 ? (count_q < TWO_C) : (pop && (count_q == '0));

   forth_stack_ram #(.DEPTH(DEPTH), .AW(CW)) u_ram (
      .clk     (clk),
      .reset   (reset),
      .we      (we_s),
      .waddr   (sp_s),
      .wdata   (nos_q),
      .raddr_a (sp_s - ONE_C),
      .rdata_a (rd_a_s),
      .raddr_b (sp_s - TWO_C),
      .rdata_b (rd_b_s)
   );

   // Next-state for the cached top, count and flags.
   always_comb begin
      tos_d   = tos_q;
      nos_d   = nos_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      we_s    = 1'b0;
      if (under_s) begin
         // Stack drains to empty, then any push lands on it.
         unf_d   = 1'b1;
         tos_d   = push ? value : '0;
         nos_d   = '0;
         count_d = push ? ONE_C : '0;
      end else begin
         case (op_s)
            OP_HOLD: begin
               tos_d = tos_q;
            end
            OP_PUSH: begin
               if (count_q == DEPTH_C) begin
                  ovf_d = 1'b1;
               end else begin
                  we_s    = (count_q >= TWO_C);
                  nos_d   = tos_q;
                  tos_d   = value;
                  count_d = count_q + ONE_C;
               end
            end
            OP_POP: begin
               tos_d   = nos_q;
               nos_d   = fill1_s;
               count_d = count_q - ONE_C;
            end
            OP_POP_PUSH: begin
               tos_d = value;
            end
            OP_POP2: begin
               tos_d   = fill1_s;
               nos_d   = fill2_s;
               count_d = count_q - TWO_C;
            end
            OP_POP2_PUSH: begin
               tos_d   = value;
               nos_d   = fill1_s;
               count_d = count_q - ONE_C;
            end
            default: begin
               tos_d = tos_q;
            end
         endcase
      end
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         tos_q   <= '0;
         nos_q   <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         tos_q   <= tos_d;
         nos_q   <= nos_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign first     = tos_q;
   assign second    = nos_q;
   assign count     = count_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_forth_stack.sv
// Scoreboard bench for forth_stack: a queue-based stack model predicts the
// state after each cycle; a monitor compares one cycle later.
module tb_forth_stack;
   import forth_stack_pkg::*;

   localparam int DEPTH = 16;
   localparam int CW    = 5;

   logic          clk = 1'b0;
   logic          reset, pop, pop2, push;
   logic [DW-1:0] value, first, second;
   logic [CW-1:0] count;
   logic          full, empty, overflow, underflow;

   always #5 clk = ~clk;

   forth_stack #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .reset(reset), .pop(pop), .pop2(pop2),
      .first(first), .second(second), .push(push), .value(value),
      .count(count), .full(full), .empty(empty),
      .overflow(overflow), .underflow(underflow)
   );

   typedef struct packed {
      logic [DW-1:0] first;
      logic [DW-1:0] second;
      logic [CW-1:0] count;
      logic          full;
      logic          empty;
      logic          ovf;
      logic          unf;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] stk[$];
   bit            m_ovf, m_unf;
   int            errors = 0;
   int            checks = 0;

   // Reference model: a plain queue, top at the back.
   task automatic step(input bit r, input bit p, input bit p2, input bit pu, input logic [DW-1:0] v);
      exp_t e;
      int   n;
      if (r) begin
         stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         n = p2 ? 2 : (p ? 1 : 0);
         if (n > stk.size()) begin
            m_unf = 1'b1;
            stk.delete();
         end else begin
            for (int k = 0; k < n; k++) void'(stk.pop_back());
         end
         if (pu) begin
            if (n == 0 && stk.size() == DEPTH) m_ovf = 1'b1;
            else stk.push_back(v);
         end
      end
      e.first  = (stk.size() > 0) ? stk[stk.size()-1] : '0;
      e.second = (stk.size() > 1) ? stk[stk.size()-2] : '0;
      e.count  = CW'(stk.size());
      e.full   = (stk.size() == DEPTH);
      e.empty  = (stk.size() == 0);
      e.ovf    = m_ovf;
      e.unf    = m_unf;
      reset = r; pop = p; pop2 = p2; push = pu; value = v;
      @(posedge clk);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: compare DUT state against the oldest prediction.
   always @(negedge clk) begin
      exp_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = '{first, second, count, full, empty, overflow, underflow};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL state @%0t: got first=%0d second=%0d count=%0d full=%b empty=%b ovf=%b unf=%b; expected first=%0d second=%0d count=%0d full=%b empty=%b ovf=%b unf=%b",
                     $time, a.first, a.second, a.count, a.full, a.empty, a.ovf, a.unf,
                     e.first, e.second, e.count, e.full, e.empty, e.ovf, e.unf);
         end
      end
   end

   initial begin
      int pick, bias;
      reset = 1'b1; pop = 1'b0; pop2 = 1'b0; push = 1'b0; value = '0;
      step(1, 0, 0, 0, 16'd0);
      // 1: push/pop basics
      step(0, 0, 0, 1, 16'd5); step(0, 0, 0, 1, 16'd7); step(0, 0, 0, 1, 16'd9);
      step(0, 1, 0, 0, 16'd0);
      // 2: ADD form on {5,7,9}
      step(0, 0, 0, 1, 16'd9);
      step(0, 0, 1, 1, 16'd16);
      // 3: fill, overflow, replace-top at full
      step(1, 0, 0, 0, 16'd0);
      for (int i = 1; i <= 16; i++) step(0, 0, 0, 1, 16'(i));
      step(0, 0, 0, 1, 16'd99);
      step(0, 1, 0, 1, 16'd42);
      // 4: underflow cases
      step(1, 0, 0, 0, 16'd0);
      step(0, 1, 0, 0, 16'd0);
      step(0, 0, 0, 1, 16'd11);
      step(0, 0, 1, 1, 16'd3);
      // 5: spill/fill path
      step(1, 0, 0, 0, 16'd0);
      for (int i = 1; i <= 16; i++) step(0, 0, 0, 1, 16'(i));
      for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 16'd0);
      // 6: reset wins over push
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 16'(i + 20));
      step(1, 0, 0, 1, 16'd8);
      step(0, 0, 0, 1, 16'd8);
      step(1, 0, 0, 0, 16'd0);
      // Random phases alternating push-heavy and pop-heavy traffic
      for (int i = 0; i < 2000; i++) begin
         bias = ((i / 100) % 2 == 0) ? 60 : 25;
         pick = $urandom_range(0, 99);
         if ($urandom_range(0, 299) == 0) begin
            step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 16'($urandom));
         end else if (pick < bias) begin
            step(0, 0, 0, 1, 16'($urandom));
         end else begin
            step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 16'($urandom));
         end
      end
      reset = 1'b0; pop = 1'b0; pop2 = 1'b0; push = 1'b0;
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
